teller_dispatcher: RTL and testbench
====================================

# teller_dispatcher

Customer-flow controller for the bank queue. It sequences the 3-bit occupancy counter and shares waiting customers among tellers. It converts entrance-sensor pulses into `up_count` pulses, refuses arrivals when the hall is full, and hands the next waiting customer to a requesting teller by round-robin arbitration, issuing the matching `down_count` pulse. It sits between the door sensor, the teller call buttons, and the occupancy counter/flags logic.

## Interface
- `N_TELLERS`, default 3: number of teller stations, legal range 2..4.
- `ACK_TIMEOUT`, default 255: cycles a granted teller may hold its request before release; used only with the timeout feature; 8-bit.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high; sampled on the rising edge of `clk`.
- `enter`  in  1: one-cycle arrival pulse from the entrance sensor.
- `teller_req`  in  N_TELLERS: level request per teller, "ready for next customer".
- `pcount`  in  3: current occupancy from the counter (0..7).
- `up_count`  out  1: registered one-cycle increment pulse to the counter.
- `down_count`  out  1: registered one-cycle decrement pulse to the counter.
- `reject`  out  1: registered one-cycle pulse; an arrival was refused because the hall was full.
- `grant`  out  N_TELLERS: one-hot, the teller currently being served a customer.
- `call_teller`  out  clog2(N_TELLERS): index of the granted teller; drives the call display.
- `served_total`  out  8: customers dispatched since reset; wraps 255→0.
- `ack_timeout`  out  1: one-cycle pulse on forced release; tied 0 when the timeout feature is compiled out.

## Operation
- **Reset values:** all outputs are 0 and the state is IDLE. The round-robin pointer `rr_ptr` is 0 and the timeout counter is 0. A reset asserted mid-grant drops `grant` on the next edge. Any in-flight pulse is not reissued.
- **Effective occupancy:** `occ_eff = pcount + up_count − down_count`, computed 4 bits wide. It accounts for pulses asserted this cycle that `pcount` does not yet reflect. Every decision uses `occ_eff`, never raw `pcount`.
- **Arrival path:** runs independently of the FSM, every cycle.
  - If `enter`=1 and (`occ_eff` < 7 or a dispatch is decided this cycle), then `up_count`=1 next cycle.
  - Otherwise, if `enter`=1, then `reject`=1 next cycle and `up_count` stays 0.
- **FSM states:**
  - **IDLE:** if any `teller_req` bit is 1 and `occ_eff` ≥ 1, pick teller `i` and go to CALL.
    - Pick `i` as the first set bit searching upward from `rr_ptr`, wrapping at N_TELLERS.
    - An arrival in the same cycle does not make `occ_eff` ≥ 1 by itself.
  - **CALL:** lasts exactly one cycle.
    - `down_count`=1, `grant[i]`=1, `call_teller`=i.
    - `served_total` increments.
    - `rr_ptr` becomes (i+1) mod N_TELLERS.
    - Next state is ACK.
  - **ACK:** `grant[i]` and `call_teller` hold.
    - When `teller_req[i]`=0 is sampled, go to IDLE; `grant` clears on that edge.
    - Other tellers' requests wait.
- **Simultaneous events:**
  - `up_count` and `down_count` may both be 1 in the same cycle; the counter must then hold its value.
  - `enter` arriving while `occ_eff`=7 is accepted only if the dispatch decision is made in that same IDLE cycle.
- **Teller dropping request while unserved:** no effect; arbitration is re-evaluated every IDLE cycle.

## Timing
- `enter` high in cycle t → `up_count` or `reject` high in cycle t+1 only.
- IDLE dispatch decision in cycle t:
  - CALL occupies t+1, with `down_count`, `grant` and `call_teller` valid in t+1.
  - ACK begins at t+2.
- Minimum spacing between two `down_count` pulses is 3 cycles: CALL, at least one ACK cycle, IDLE.
- Back-to-back `enter` pulses are each handled in the following cycle; `occ_eff` prevents exceeding 7.

## Configuration
- `TELLER_DISPATCH_TIMEOUT_EN` defined:
  - An 8-bit counter runs in ACK.
  - If `teller_req[i]` is still 1 after ACK_TIMEOUT ACK cycles, the FSM goes to IDLE, clears `grant`, and pulses `ack_timeout` for one cycle.
  - `rr_ptr` has already advanced, so another requesting teller is preferred next.
- Not defined: ACK waits indefinitely; `ack_timeout` is constant 0 and no counter is built.

## Structure
- Package `teller_dispatch_pkg`:
  - FSM state enum (IDLE, CALL, ACK).
  - `HALL_CAPACITY` = 7.
  - `PCOUNT_W` = 3, `OCC_W` = 4, `SERVED_W` = 8.
- Sub-module `rr_arbiter`: combinational, parameterised on N_TELLERS.
  - Inputs: `req` and `ptr`.
  - Outputs: one-hot `gnt`, `gnt_idx` and `any`.

## Test plan
- Reset with `enter`=1 and `teller_req`=3'b111 → all outputs 0. Then, with `pcount`=0 and `teller_req`=3'b111, no `grant` follows.
- `pcount`=3 and `teller_req`=3'b111 held; each teller drops its request one cycle after its grant → `call_teller` sequence 0,1,2,0; `served_total`=4; `down_count` pulses 3 cycles apart.
- `pcount`=6 and two consecutive `enter` pulses with no tellers → first gives `up_count` in t+1; second gives `reject` in t+2, since `occ_eff`=7.
- `pcount`=7, `teller_req`=3'b010 and `enter`=1 in the same IDLE cycle → `up_count`=1 and `down_count`=1 in the next cycle; `reject`=0; `grant`=3'b010.
- Reset asserted during ACK with `grant`=3'b001 → `grant`=0 and state IDLE on the next edge; `rr_ptr`=0.
- With `TELLER_DISPATCH_TIMEOUT_EN` and ACK_TIMEOUT=4, teller 1 holds its request → `ack_timeout` pulses 4 cycles into ACK, then teller 2 (requesting) is granted next.

Source files
------------

// File: rtl/teller_dispatcher_pkg.sv
// Shared types and constants for the bank-hall teller dispatcher.
package teller_dispatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALL = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam int HALL_CAPACITY = 7;
  localparam int PCOUNT_W      = 3;
  localparam int OCC_W         = 4;
  localparam int SERVED_W      = 8;

endpackage

// File: rtl/teller_dispatcher_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr, wrapping at N_TELLERS.
module rr_arbiter #(
  parameter int N_TELLERS = 3,
  parameter int IDX_W     = (N_TELLERS > 1) ? $clog2(N_TELLERS) : 1
) (
  input  logic [N_TELLERS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [N_TELLERS-1:0] gnt,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic                 any
);

  logic w_found;

  assign any = |req;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    for (int k = 0; k < N_TELLERS; k++) begin
      if (!w_found && req[(int'(ptr) + k) % N_TELLERS]) begin
        w_found = 1'b1;
        gnt[(int'(ptr) + k) % N_TELLERS] = 1'b1;
        gnt_idx = IDX_W'((int'(ptr) + k) % N_TELLERS);
      end
    end
  end

endmodule

// File: rtl/teller_dispatcher.sv
// Bank-hall customer flow: arrival admission, round-robin teller dispatch, served count.
// Optional ACK timeout is built when TELLER_DISPATCH_TIMEOUT_EN is defined.
module teller_dispatcher
  import teller_dispatch_pkg::*;
#(
  parameter int         N_TELLERS   = 3,
  parameter logic [7:0] ACK_TIMEOUT = 8'd255,
  parameter int         IDX_W       = (N_TELLERS > 1) ? $clog2(N_TELLERS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enter,
  input  logic [N_TELLERS-1:0] teller_req,
  input  logic [PCOUNT_W-1:0]  pcount,
  output logic                 up_count,
  output logic                 down_count,
  output logic                 reject,
  output logic [N_TELLERS-1:0] grant,
  output logic [IDX_W-1:0]     call_teller,
  output logic [SERVED_W-1:0]  served_total,
  output logic                 ack_timeout
);

  state_t                r_state, w_state_nxt;
  logic                  r_up, r_down, r_reject;
  logic [N_TELLERS-1:0]  r_grant;
  logic [IDX_W-1:0]      r_call, r_ptr;
  logic [SERVED_W-1:0]   r_served;

  logic [OCC_W-1:0]      w_occ_eff;
  logic [N_TELLERS-1:0]  w_arb_gnt;
  logic [IDX_W-1:0]      w_arb_idx, w_ptr_nxt;
  logic                  w_arb_any, w_dispatch, w_accept, w_release, w_timeout;

  // Occupancy including pulses already sent but not yet seen on pcount.
  assign w_occ_eff = OCC_W'(pcount) + OCC_W'(r_up) - OCC_W'(r_down);

  rr_arbiter #(.N_TELLERS(N_TELLERS), .IDX_W(IDX_W)) u_arb (
    .req     (teller_req),
    .ptr     (r_ptr),
    .gnt     (w_arb_gnt),
    .gnt_idx (w_arb_idx),
    .any     (w_arb_any)
  );

  assign w_dispatch = (r_state == ST_IDLE) && w_arb_any && (w_occ_eff >= OCC_W'(1));
  assign w_accept   = enter && ((w_occ_eff < OCC_W'(HALL_CAPACITY)) || w_dispatch);
  assign w_ptr_nxt  = (w_arb_idx == IDX_W'(N_TELLERS - 1)) ? '0 : w_arb_idx + IDX_W'(1);

`ifdef TELLER_DISPATCH_TIMEOUT_EN
  logic [7:0] r_tmo_cnt;
  logic       r_ack_tmo;
  assign w_timeout = (r_state == ST_ACK) && teller_req[r_call] &&
                     (r_tmo_cnt == ACK_TIMEOUT - 8'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo_cnt <= '0;
      r_ack_tmo <= 1'b0;
    end else begin
      r_ack_tmo <= w_timeout;
      if ((r_state == ST_ACK) && (w_state_nxt == ST_ACK))
        r_tmo_cnt <= r_tmo_cnt + 8'd1;
      else
        r_tmo_cnt <= '0;
    end
  end
  assign ack_timeout = r_ack_tmo;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^ACK_TIMEOUT;
  assign w_timeout    = 1'b0;
  assign ack_timeout  = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_release   = 1'b0;
    unique case (r_state)
      ST_IDLE: if (w_dispatch) w_state_nxt = ST_CALL;
      ST_CALL: w_state_nxt = ST_ACK;
      ST_ACK: begin
        if (!teller_req[r_call] || w_timeout) begin
          w_state_nxt = ST_IDLE;
          w_release   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_up     <= 1'b0;
      r_down   <= 1'b0;
      r_reject <= 1'b0;
      r_grant  <= '0;
      r_call   <= '0;
      r_ptr    <= '0;
      r_served <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_up     <= w_accept;
      r_reject <= enter && !w_accept;
      r_down   <= w_dispatch;
      if (w_dispatch) begin
        r_grant  <= w_arb_gnt;
        r_call   <= w_arb_idx;
        r_ptr    <= w_ptr_nxt;
        r_served <= r_served + SERVED_W'(1);
      end else if (w_release) begin
        r_grant  <= '0;
      end
    end
  end

  assign up_count     = r_up;
  assign down_count   = r_down;
  assign reject       = r_reject;
  assign grant        = r_grant;
  assign call_teller  = r_call;
  assign served_total = r_served;

endmodule

// File: tb/tb_teller_dispatcher.sv
// Scoreboard bench for teller_dispatcher with a closed-loop occupancy counter model.
module tb_teller_dispatcher;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enter = 1'b0;
  logic [N-1:0] teller_req = '0;
  logic [2:0]   pcount = 3'd0;
  logic         up_count, down_count, reject, ack_timeout;
  logic [N-1:0] grant;
  logic [1:0]   call_teller;
  logic [7:0]   served_total;

  always #5 clk = ~clk;

  teller_dispatcher #(.N_TELLERS(N), .ACK_TIMEOUT(8'd255)) dut (
    .clk          (clk),
    .reset        (reset),
    .enter        (enter),
    .teller_req   (teller_req),
    .pcount       (pcount),
    .up_count     (up_count),
    .down_count   (down_count),
    .reject       (reject),
    .grant        (grant),
    .call_teller  (call_teller),
    .served_total (served_total),
    .ack_timeout  (ack_timeout)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // The occupancy counter the dispatcher drives; loadable for directed scenarios.
  bit       do_load = 1'b0;
  logic [2:0] load_val = 3'd0;
  always @(posedge clk) begin
    if (do_load) pcount <= load_val;
    else         pcount <= pcount + {2'b0, up_count} - {2'b0, down_count};
  end

  typedef struct { int cyc; int idx; int served; } call_t;
  int           up_q[$];
  int           rej_q[$];
  call_t        call_q[$];
  logic [N-1:0] exp_g [int];
  bit           rst_chk [int];
  int n_err = 0;
  int n_chk = 0;

  // Reference model: customers in hall, pointer, served count, busy teller.
  int m_occ = 0, m_ptr = 0, m_served = 0, m_gnt = -1, m_dec = 0;

  task automatic model(input bit e, input logic [N-1:0] rq, input bit rs, input int c);
    int pick;
    logic [N-1:0] oh;
    pick = -1;
    oh = '0;
    if (rs) begin
      m_ptr = 0; m_served = 0; m_gnt = -1;
      rst_chk[c+1] = 1'b1;
      exp_g[c+1] = '0;
      return;
    end
    if (m_gnt < 0 && rq != '0 && m_occ >= 1)
      for (int k = 0; k < N; k++)
        if (pick < 0 && rq[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
    if (e) begin
      if (m_occ < 7 || pick >= 0) begin m_occ++; up_q.push_back(c+1); end
      else rej_q.push_back(c+1);
    end
    if (pick >= 0) begin
      m_occ--;
      m_served = (m_served + 1) % 256;
      call_q.push_back('{c+1, pick, m_served});
      m_ptr = (pick + 1) % N;
      m_gnt = pick;
      m_dec = c;
      oh[pick] = 1'b1;
    end else if (m_gnt >= 0) begin
      if (c >= m_dec + 2 && !rq[m_gnt]) m_gnt = -1;
      else oh[m_gnt] = 1'b1;
    end
    exp_g[c+1] = oh;
  endtask

  task automatic step(input bit e, input logic [N-1:0] rq, input bit rs);
    enter = e; teller_req = rq; reset = rs;
    model(e, rq, rs, cyc);
    @(posedge clk); #1;
  endtask

  task automatic load(input int v);
    step(1'b0, '0, 1'b0);
    do_load = 1'b1; load_val = 3'(v);
    step(1'b0, '0, 1'b0);
    do_load = 1'b0;
    m_occ = v;
  endtask

  always @(negedge clk) begin : monitor
    int c;
    call_t ce;
    c = cyc;
    if (rst_chk.exists(c)) begin
      n_chk++;
      if ({up_count, down_count, reject, grant, call_teller, served_total, ack_timeout} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs cyc=%0d got up=%b dn=%b rej=%b gnt=%b call=%0d served=%0d tmo=%b exp all 0",
                 c, up_count, down_count, reject, grant, call_teller, served_total, ack_timeout);
      end
      rst_chk.delete(c);
    end
    if (exp_g.exists(c)) begin
      n_chk++;
      if (grant !== exp_g[c]) begin
        n_err++;
        $display("FAIL grant cyc=%0d got=%b exp=%b", c, grant, exp_g[c]);
      end
      exp_g.delete(c);
    end
`ifndef TELLER_DISPATCH_TIMEOUT_EN
    if (c >= 3) begin
      n_chk++;
      if (ack_timeout !== 1'b0) begin
        n_err++;
        $display("FAIL ack_timeout cyc=%0d got=%b exp=0", c, ack_timeout);
      end
    end
`endif
    while (up_q.size() > 0 && up_q[0] < c) begin
      n_chk++; n_err++;
      $display("FAIL up_missing got none exp cyc=%0d", up_q.pop_front());
    end
    while (rej_q.size() > 0 && rej_q[0] < c) begin
      n_chk++; n_err++;
      $display("FAIL reject_missing got none exp cyc=%0d", rej_q.pop_front());
    end
    while (call_q.size() > 0 && call_q[0].cyc < c) begin
      ce = call_q.pop_front();
      n_chk++; n_err++;
      $display("FAIL down_missing got none exp cyc=%0d teller=%0d", ce.cyc, ce.idx);
    end
    if (up_count === 1'b1) begin
      n_chk++;
      if (up_q.size() == 0 || up_q[0] != c) begin
        n_err++;
        $display("FAIL up_unexpected got up_count=1 at cyc=%0d exp none", c);
      end else void'(up_q.pop_front());
    end
    if (reject === 1'b1) begin
      n_chk++;
      if (rej_q.size() == 0 || rej_q[0] != c) begin
        n_err++;
        $display("FAIL reject_unexpected got reject=1 at cyc=%0d exp none", c);
      end else void'(rej_q.pop_front());
    end
    if (down_count === 1'b1) begin
      n_chk++;
      if (call_q.size() == 0 || call_q[0].cyc != c) begin
        n_err++;
        $display("FAIL down_unexpected got down_count=1 at cyc=%0d exp none", c);
      end else begin
        ce = call_q.pop_front();
        if (int'(call_teller) != ce.idx || int'(served_total) != ce.served) begin
          n_err++;
          $display("FAIL call cyc=%0d got teller=%0d served=%0d exp teller=%0d served=%0d",
                   c, call_teller, served_total, ce.idx, ce.served);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] rq;
    @(posedge clk); #1;
    // Reset with arrivals and all tellers asking, then an empty hall.
    repeat (3) step(1'b1, 3'b111, 1'b1);
    repeat (5) step(1'b0, 3'b111, 1'b0);
    // Rotation across all tellers, each releasing one cycle after its grant.
    load(3);
    for (int i = 0; i < 13; i++) begin
      rq = 3'b111;
      if (m_gnt >= 0 && cyc >= m_dec + 2) rq[m_gnt] = 1'b0;
      step(i == 1, rq, 1'b0);
    end
    repeat (3) step(1'b0, 3'b000, 1'b0);
    // Nearly full hall: second back-to-back arrival is refused.
    load(6);
    step(1'b1, 3'b000, 1'b0);
    step(1'b1, 3'b000, 1'b0);
    step(1'b0, 3'b000, 1'b0);
    // Full hall: arrival accepted only because a dispatch happens the same cycle.
    step(1'b1, 3'b010, 1'b0);
    step(1'b0, 3'b010, 1'b0);
    repeat (3) step(1'b0, 3'b000, 1'b0);
    // Reset while teller 0 is in ACK, then pointer restarts at teller 0.
    load(2);
    repeat (4) step(1'b0, 3'b001, 1'b0);
    step(1'b0, 3'b001, 1'b1);
    step(1'b0, 3'b111, 1'b0);
    repeat (3) step(1'b0, 3'b000, 1'b0);
    // Randomized traffic.
    for (int i = 0; i < 500; i++)
      step(($urandom % 3) == 0, 3'($urandom), ($urandom % 150) == 0);
    repeat (8) step(1'b0, 3'b000, 1'b0);
    @(negedge clk); #1;
    n_chk++;
    if (up_q.size() + rej_q.size() + call_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_events got %0d outstanding exp 0", up_q.size() + rej_q.size() + call_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
